// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL reset sequencer: state encoding and counter sizing.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        HOLD,
        RUN,
        FAIL
    } seq_state_t;

    // Width of a down-counter able to hold the largest of the four counts, plus one bit.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_reset_seq_sync2.sv
// Two-flop synchronizer with asynchronous active-high reset.
module sync2 (
    input  logic clock_in,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL bring-up sequencer: pulses PLL reset, qualifies lock, then releases sys_reset.
// Optional macro PLL_LOCK_RECOVERY_EN: lock loss in RUN triggers a full re-bring-up.
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 4,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int RELEASE_HOLD_CYCLES = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       pll_locked,
    output logic       pll_resetb,
    output logic       sys_reset,
    output logic       seq_error,
    output logic       lock_lost,
    output logic [1:0] retry_cnt
);

    localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                  LOCK_STABLE_CYCLES, RELEASE_HOLD_CYCLES);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t ONE = cnt_t'(1);

    logic       lock_s;
    seq_state_t state, state_next;
    cnt_t       cnt, cnt_next;
    logic [1:0] retry_next;
    logic       lock_lost_next;
    logic       pll_resetb_next;
    logic       sys_reset_next;
    logic       seq_error_next;

    sync2 u_sync (
        .clock_in (clock_in),
        .reset    (reset),
        .d        (pll_locked),
        .q        (lock_s)
    );

    // A count loaded with N keeps the state for exactly N cycles (exit when cnt reaches 1).
    always_comb begin
        state_next     = state;
        cnt_next       = (cnt != '0) ? cnt - ONE : '0;
        retry_next     = retry_cnt;
        lock_lost_next = lock_lost;
        case (state)
            PLL_RST: begin
                if (cnt <= ONE) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = cnt_t'(LOCK_TIMEOUT_CYCLES);
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_next = STABLE;
                    cnt_next   = cnt_t'(LOCK_STABLE_CYCLES);
                end else if (cnt <= ONE) begin
                    retry_next = retry_cnt + 2'd1;
                    if (int'(retry_cnt) + 1 == MAX_RETRIES) begin
                        state_next = FAIL;
                        cnt_next   = '0;
                    end else begin
                        state_next = PLL_RST;
                        cnt_next   = cnt_t'(PLL_RST_CYCLES);
                    end
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = cnt_t'(LOCK_TIMEOUT_CYCLES);
                end else if (cnt <= ONE) begin
                    state_next = HOLD;
                    cnt_next   = cnt_t'(RELEASE_HOLD_CYCLES);
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = cnt_t'(LOCK_TIMEOUT_CYCLES);
                end else if (cnt <= ONE) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                retry_next = 2'd0;
                cnt_next   = '0;
                if (!lock_s) begin
                    lock_lost_next = 1'b1;
`ifdef PLL_LOCK_RECOVERY_EN
                    state_next = PLL_RST;
                    cnt_next   = cnt_t'(PLL_RST_CYCLES);
`endif
                end
            end
            FAIL: begin
                cnt_next = '0;
            end
            default: begin
                state_next = PLL_RST;
                cnt_next   = cnt_t'(PLL_RST_CYCLES);
            end
        endcase

        pll_resetb_next = !(state_next == PLL_RST || state_next == FAIL);
        seq_error_next  = (state_next == FAIL);
`ifdef PLL_LOCK_RECOVERY_EN
        sys_reset_next  = (state_next != RUN);
`else
        // Without recovery a lost lock parks RUN with downstream held in reset.
        sys_reset_next  = !(state_next == RUN && !lock_lost_next);
`endif
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state      <= PLL_RST;
            cnt        <= cnt_t'(PLL_RST_CYCLES);
            pll_resetb <= 1'b0;
            sys_reset  <= 1'b1;
            seq_error  <= 1'b0;
            lock_lost  <= 1'b0;
            retry_cnt  <= 2'd0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            pll_resetb <= pll_resetb_next;
            sys_reset  <= sys_reset_next;
            seq_error  <= seq_error_next;
            lock_lost  <= lock_lost_next;
            retry_cnt  <= retry_next;
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed self-checking bench for pll_reset_seq (honours PLL_LOCK_RECOVERY_EN if defined).
module tb_pll_reset_seq;

    logic       clock_in = 1'b0;
    logic       reset    = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_resetb;
    logic       sys_reset;
    logic       seq_error;
    logic       lock_lost;
    logic [1:0] retry_cnt;

    int checks = 0;
    int errors = 0;
    int n;
    int lows;

    always #5 clock_in = ~clock_in;

    pll_reset_seq #(
        .PLL_RST_CYCLES      (4),
        .LOCK_TIMEOUT_CYCLES (64),
        .LOCK_STABLE_CYCLES  (8),
        .RELEASE_HOLD_CYCLES (16),
        .MAX_RETRIES         (3)
    ) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .pll_locked (pll_locked),
        .pll_resetb (pll_resetb),
        .sys_reset  (sys_reset),
        .seq_error  (seq_error),
        .lock_lost  (lock_lost),
        .retry_cnt  (retry_cnt)
    );

    function automatic logic sig_of(input int sel);
        case (sel)
            0:       return pll_resetb;
            1:       return sys_reset;
            default: return seq_error;
        endcase
    endfunction

    // Counts rising edges until the selected output reaches val; -1 if the bound expires.
    task automatic wait_for(input int sel, input logic val, input int limit, output int cnt);
        cnt = -1;
        for (int i = 1; i <= limit && cnt < 0; i++) begin
            @(posedge clock_in);
            #1;
            if (sig_of(sel) === val) cnt = i;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pll_locked = 1'b0;
        repeat (3) @(posedge clock_in);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pll_locked = 1'b1;
        repeat (3) @(posedge clock_in);
        #1;
        checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL reset_pll_resetb got %b exp 0", pll_resetb); end
        checks++; if (sys_reset !== 1'b1) begin errors++; $display("FAIL reset_sys_reset got %b exp 1", sys_reset); end
        checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL reset_seq_error got %b exp 0", seq_error); end
        checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL reset_lock_lost got %b exp 0", lock_lost); end
        checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL reset_retry_cnt got %0d exp 0", retry_cnt); end
        $display("reset: pll_resetb=%b sys_reset=%b seq_error=%b", pll_resetb, sys_reset, seq_error);
    endtask

    task automatic test_timeout();
        do_reset();
        wait_for(0, 1'b1, 20, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL to_pulse1_len got %0d exp 4", n); end
        wait_for(0, 1'b0, 100, n);
        checks++; if (n !== 64) begin errors++; $display("FAIL to_gap1 got %0d exp 64", n); end
        checks++; if (retry_cnt !== 2'd1) begin errors++; $display("FAIL to_retry1 got %0d exp 1", retry_cnt); end
        wait_for(0, 1'b1, 20, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL to_pulse2_len got %0d exp 4", n); end
        wait_for(0, 1'b0, 100, n);
        checks++; if (n !== 64) begin errors++; $display("FAIL to_gap2 got %0d exp 64", n); end
        checks++; if (retry_cnt !== 2'd2) begin errors++; $display("FAIL to_retry2 got %0d exp 2", retry_cnt); end
        checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL to_early_error got %b exp 0", seq_error); end
        wait_for(0, 1'b1, 20, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL to_pulse3_len got %0d exp 4", n); end
        wait_for(0, 1'b0, 100, n);
        checks++; if (n !== 64) begin errors++; $display("FAIL to_gap3 got %0d exp 64", n); end
        checks++; if (seq_error !== 1'b1) begin errors++; $display("FAIL to_seq_error got %b exp 1", seq_error); end
        checks++; if (sys_reset !== 1'b1) begin errors++; $display("FAIL to_sys_reset got %b exp 1", sys_reset); end
        pll_locked = 1'b1;
        repeat (100) @(posedge clock_in);
        #1;
        checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL fail_sticky_resetb got %b exp 0", pll_resetb); end
        checks++; if (seq_error !== 1'b1) begin errors++; $display("FAIL fail_sticky_error got %b exp 1", seq_error); end
        $display("timeout: seq_error=%b pll_resetb=%b", seq_error, pll_resetb);
    endtask

    task automatic test_lock_up();
        do_reset();
        wait_for(0, 1'b1, 20, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL up_pulse_len got %0d exp 4", n); end
        repeat (10) @(posedge clock_in);
        #1;
        pll_locked = 1'b1;
        wait_for(1, 1'b0, 100, n);
        checks++; if (n !== 27) begin errors++; $display("FAIL up_release_latency got %0d exp 27", n); end
        checks++; if (pll_resetb !== 1'b1) begin errors++; $display("FAIL up_pll_resetb got %b exp 1", pll_resetb); end
        checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL up_retry got %0d exp 0", retry_cnt); end
        checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL up_lock_lost got %b exp 0", lock_lost); end
        $display("lock_up: release latency %0d", n);
    endtask

    task automatic test_lock_loss();
        pll_locked = 1'b0;
        wait_for(1, 1'b1, 10, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL loss_sys_reset_latency got %0d exp 3", n); end
        checks++; if (lock_lost !== 1'b1) begin errors++; $display("FAIL loss_lock_lost got %b exp 1", lock_lost); end
`ifdef PLL_LOCK_RECOVERY_EN
        checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL loss_pulse_start got %b exp 0", pll_resetb); end
        wait_for(0, 1'b1, 20, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL loss_pulse_len got %0d exp 4", n); end
        checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL loss_retry got %0d exp 0", retry_cnt); end
`else
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock_in);
            #1;
            if (pll_resetb !== 1'b1) lows++;
        end
        checks++; if (lows !== 0) begin errors++; $display("FAIL loss_resetb_low_cycles got %0d exp 0", lows); end
        pll_locked = 1'b1;
        repeat (40) @(posedge clock_in);
        #1;
        checks++; if (sys_reset !== 1'b1) begin errors++; $display("FAIL loss_sys_reset_held got %b exp 1", sys_reset); end
`endif
        $display("lock_loss: lock_lost=%b sys_reset=%b", lock_lost, sys_reset);
    endtask

    task automatic test_glitch();
        do_reset();
        wait_for(0, 1'b1, 20, n);
        pll_locked = 1'b1;
        repeat (6) @(posedge clock_in);
        #1;
        pll_locked = 1'b0;
        @(posedge clock_in);
        #1;
        pll_locked = 1'b1;
        wait_for(1, 1'b0, 100, n);
        checks++; if (n !== 27) begin errors++; $display("FAIL glitch_requalify got %0d exp 27", n); end
        $display("glitch: release %0d cycles after re-rise", n);
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        wait_for(0, 1'b1, 20, n);
        pll_locked = 1'b1;
        repeat (15) @(posedge clock_in);
        #1;
        checks++; if (sys_reset !== 1'b1) begin errors++; $display("FAIL hold_sys_reset got %b exp 1", sys_reset); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL hold_abort_resetb got %b exp 0", pll_resetb); end
        checks++; if (sys_reset !== 1'b1) begin errors++; $display("FAIL hold_abort_sys_reset got %b exp 1", sys_reset); end
        checks++; if (seq_error !== 1'b0) begin errors++; $display("FAIL hold_abort_error got %b exp 0", seq_error); end
        repeat (2) @(posedge clock_in);
        #1;
        reset = 1'b0;
        wait_for(0, 1'b1, 20, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL hold_restart_pulse got %0d exp 4", n); end
        wait_for(1, 1'b0, 100, n);
        checks++; if (n !== 25) begin errors++; $display("FAIL hold_restart_release got %0d exp 25", n); end
        $display("reset_in_hold: restart release %0d", n);
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_lock_up();
        test_lock_loss();
        test_glitch();
        test_reset_in_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
